// File: rtl/i2c_bus_cond_detector.sv
// I2C bus-condition monitor: synchronises and glitch-filters raw SDA/SCL, then reports
// START / repeated START / STOP / SCL edges, bus busy/free state and SCL stuck-low.
`timescale 1ns/1ps

module i2c_bus_cond_detector #(
  parameter int SYNC_STAGES     = 2,
  parameter int FILT_LEN        = 3,
  parameter int BUS_FREE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sda_in,
  input  logic scl_in,
  output logic sda_f,
  output logic scl_f,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic scl_rise,
  output logic scl_fall,
  output logic bus_busy,
  output logic bus_free,
  output logic scl_timeout,
  output logic scl_stuck
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int BW = $clog2(BUS_FREE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [BW-1:0] FREE_MAX = BW'(BUS_FREE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_PRE  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    BUS_IDLE   = 1'b0,
    BUS_ACTIVE = 1'b1
  } bus_state_t;

  logic [SYNC_STAGES-1:0] sda_sync;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] prime;
  logic                   sda_s;
  logic                   scl_s;
  logic [FW-1:0]          sda_cnt;
  logic [FW-1:0]          scl_cnt;
  logic                   sda_fd;
  logic                   scl_fd;
  logic                   armed;
  logic [BW-1:0]          free_cnt;
  logic [TW-1:0]          tmo_cnt;
  bus_state_t             bus_state;

  logic start_c;
  logic stop_c;
  logic rise_raw;
  logic rise_c;
  logic fall_c;
  logic tmo_c;

  // prime marks when the synchroniser chain holds real pin samples rather than reset ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_sync <= '1;
      scl_sync <= '1;
      prime    <= '0;
    end else begin
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      prime    <= {prime[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_s = scl_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_f   <= 1'b1;
      sda_cnt <= '0;
    end else if (sda_s == sda_f) begin
      sda_cnt <= '0;
    end else if (sda_cnt == FILT_MAX) begin
      sda_f   <= ~sda_f;
      sda_cnt <= '0;
    end else begin
      sda_cnt <= sda_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_f   <= 1'b1;
      scl_cnt <= '0;
    end else if (scl_s == scl_f) begin
      scl_cnt <= '0;
    end else if (scl_cnt == FILT_MAX) begin
      scl_f   <= ~scl_f;
      scl_cnt <= '0;
    end else begin
      scl_cnt <= scl_cnt + FW'(1);
    end
  end

  // Edges caused only by the filters converging from their reset value of 1 are not bus
  // events, so detection waits until both filtered lines agree with real pin samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (prime[SYNC_STAGES-1] && (sda_s == sda_f) && (scl_s == scl_f)) begin
      armed <= 1'b1;
    end
  end

  assign start_c  = armed & sda_fd & ~sda_f & scl_fd & scl_f;
  assign stop_c   = armed & ~sda_fd & sda_f & scl_fd & scl_f;
  assign rise_raw = scl_f & ~scl_fd;
  assign rise_c   = armed & rise_raw;
  assign fall_c   = armed & ~scl_f & scl_fd;
  assign tmo_c    = ~scl_f & (tmo_cnt == TMO_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_fd      <= 1'b1;
      scl_fd      <= 1'b1;
      start_det   <= 1'b0;
      rstart_det  <= 1'b0;
      stop_det    <= 1'b0;
      scl_rise    <= 1'b0;
      scl_fall    <= 1'b0;
      scl_timeout <= 1'b0;
      scl_stuck   <= 1'b0;
      bus_state   <= BUS_IDLE;
      free_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      sda_fd      <= sda_f;
      scl_fd      <= scl_f;
      start_det   <= start_c & (bus_state == BUS_IDLE);
      rstart_det  <= start_c & (bus_state == BUS_ACTIVE);
      stop_det    <= stop_c;
      scl_rise    <= rise_c;
      scl_fall    <= fall_c;
      scl_timeout <= tmo_c;

      case (bus_state)
        BUS_IDLE:   if (start_c) bus_state <= BUS_ACTIVE;
        BUS_ACTIVE: if (stop_c || tmo_c) bus_state <= BUS_IDLE;
        default:    bus_state <= BUS_IDLE;
      endcase

      if (tmo_c) begin
        scl_stuck <= 1'b1;
      end else if (rise_raw) begin
        scl_stuck <= 1'b0;
      end

      // Saturating at TMO_MAX is what stops a second timeout pulse during one long low
      if (scl_f) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if ((bus_state == BUS_IDLE) && sda_f && scl_f) begin
        if (free_cnt != FREE_MAX) free_cnt <= free_cnt + BW'(1);
      end else begin
        free_cnt <= '0;
      end
    end
  end

  assign bus_busy = (bus_state == BUS_ACTIVE);
  assign bus_free = (free_cnt == FREE_MAX);

endmodule
